persiana_motor_model: RTL and testbench
=======================================

# persiana_motor_model

Synthesizable plant model of the automatic-blind motor and end-stop switches, used as the counterpart of the blind-control FSM. It consumes the controller's motor-up/motor-down commands, integrates them into a blind position, and returns the top/bottom limit-switch signals the controller senses. It sits between the controller outputs and inputs in the tile-level testbench, and can also be instantiated on-chip as a loop-back demo.

## Interface
- TRAVEL_STEPS, 200: steps from fully open (0) to fully closed; range 1..255
- STEP_DIV, 4: clock cycles per position step; ≥1
- DWELL, 8: mandatory motor-stopped cycles after any stop or reversal; ≥1
- STALL_LIMIT, 16: consecutive cycles a command may push into its active limit before fault (stall feature only)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; 0 freezes all state, counters and outputs
- motor_up  in  1  command: raise blind (position decreases)
- motor_down  in  1  command: lower blind (position increases)
- position  out  8  current position, 0 = open/top, TRAVEL_STEPS = closed/bottom
- limit_top  out  1  high when position == 0
- limit_bottom  out  1  high when position == TRAVEL_STEPS
- moving  out  1  high in UP or DOWN state
- fault  out  1  high in FAULT state

## Operation
- Reset values: state IDLE, position 0, limit_top 1, limit_bottom 0, moving 0, fault 0, all counters 0.
- Commands sampled on rising clk when ena = 1; ena = 0 holds everything, no counter advances.
- IDLE: up only and position > 0 → UP; down only and position < TRAVEL_STEPS → DOWN; both → FAULT; command toward an already-reached limit → stay IDLE.
- UP/DOWN: prescaler counts 0..STEP_DIV-1; on wrap position steps by 1 toward target. Reaching the limit → IDLE on the same edge as the final step (no dwell). Command released or opposite command alone → DWELL. Both commands → FAULT.
- DWELL: counter runs DWELL cycles, commands ignored except both high → FAULT; on expiry → IDLE.
- FAULT: position frozen; leaves to IDLE on the first edge where both commands sampled low.
- Position never leaves 0..TRAVEL_STEPS; no wrap-around.
- limit_top/limit_bottom decoded from the position register, valid the same cycle position updates.

## Timing
- Command sampled at edge N → moving = 1 after edge N; first position change after edge N+STEP_DIV.
- Prescaler cleared on every entry into UP/DOWN; partial steps discarded on stop.
- Full travel open→closed: TRAVEL_STEPS·STEP_DIV cycles after the start edge.
- Reversal: minimum DWELL+1 cycles from the release edge to renewed motion.
- Reset asserted mid-move: outputs return to reset values immediately (asynchronously), position returns to 0.

## Configuration
- PERSIANA_STALL_DETECT_EN defined: in IDLE, a command toward the active limit (up at position 0, down at TRAVEL_STEPS) held for STALL_LIMIT consecutive sampled cycles → FAULT; counter clears when command drops or changes.
- Undefined: such commands are ignored indefinitely; stall counter and STALL_LIMIT logic absent, fault only from both-commands.

## Structure
- persiana_pkg: state enum (IDLE, UP, DOWN, DWELL, FAULT), default parameter constants, position width constant (8).
- One sub-module: persiana_step_prescaler (STEP_DIV counter with clear and ena, emits one-cycle step tick).

## Test plan
- Reset, TRAVEL_STEPS=10, STEP_DIV=4: motor_down held → position 1 after 4 cycles, 10 after 40, limit_bottom=1, moving=0, state IDLE.
- At position 5 moving down, drop motor_down and raise motor_up → DWELL 8 cycles, no position change; then UP, position 4 after 4 more cycles.
- motor_up and motor_down both high while moving → fault=1 next cycle, position frozen; both low → fault=0, IDLE.
- ena=0 for 20 cycles mid-move → position, prescaler, outputs unchanged; resumes exact step phase on ena=1.
- With PERSIANA_STALL_DETECT_EN: motor_up held at position 0 → fault=1 after exactly 16 cycles; without macro, fault stays 0 for 100 cycles.
- rst_n pulsed low at position 7 between clock edges → position 0, limit_top=1, moving=0 immediately.

Source files
------------

// File: rtl/persiana_pkg.sv
`default_nettype none
// ============================================================================
// Module  : persiana_pkg
// Brief   : Shared types and default constants for the blind motor plant model.
// Rev     : 1.0
// ============================================================================
package persiana_pkg;

    localparam int POS_W            = 8;
    localparam int DEF_TRAVEL_STEPS = 200;
    localparam int DEF_STEP_DIV     = 4;
    localparam int DEF_DWELL        = 8;
    localparam int DEF_STALL_LIMIT  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_DWELL = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/persiana_step_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : persiana_step_prescaler
// Brief   : Counts STEP_DIV enabled cycles and emits a one-cycle step tick.
// Rev     : 1.0
// ============================================================================
module persiana_step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = ena & ~i_clear & w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (i_clear || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/persiana_motor_model.sv
`default_nettype none
// ============================================================================
// Module  : persiana_motor_model
// Brief   : Blind motor / end-stop plant model driven by up/down commands.
//           Optional stall-to-fault detection: PERSIANA_STALL_DETECT_EN.
// Rev     : 1.0
// ============================================================================
module persiana_motor_model
    import persiana_pkg::*;
#(
    parameter int TRAVEL_STEPS = DEF_TRAVEL_STEPS,
    parameter int STEP_DIV     = DEF_STEP_DIV,
    parameter int DWELL        = DEF_DWELL
`ifdef PERSIANA_STALL_DETECT_EN
    ,
    parameter int STALL_LIMIT  = DEF_STALL_LIMIT
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             motor_up,
    input  logic             motor_down,
    output logic [POS_W-1:0] position,
    output logic             limit_top,
    output logic             limit_bottom,
    output logic             moving,
    output logic             fault
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(TRAVEL_STEPS);
    localparam int               DW_W    = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

    state_t            r_state, w_state_nxt;
    logic [POS_W-1:0]  r_position, w_pos_nxt;
    logic [DW_W-1:0]   r_dwell, w_dwell_nxt;
    logic              w_up_only, w_dn_only, w_both;
    logic              w_at_top, w_at_bot, w_running, w_tick, w_stall_hit;

    assign w_up_only = motor_up & ~motor_down;
    assign w_dn_only = motor_down & ~motor_up;
    assign w_both    = motor_up & motor_down;
    assign w_at_top  = (r_position == '0);
    assign w_at_bot  = (r_position == POS_MAX);
    assign w_running = (r_state == ST_UP) || (r_state == ST_DOWN);

    // Prescaler is held clear outside UP/DOWN so every motion starts a fresh step.
    persiana_step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .i_clear (~w_running),
        .o_tick  (w_tick)
    );

`ifdef PERSIANA_STALL_DETECT_EN
    localparam int              ST_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STALL_LIMIT - 1);

    logic [ST_W-1:0] r_stall;
    logic            w_stall_cond;

    assign w_stall_cond = (r_state == ST_IDLE) &&
                          ((w_up_only && w_at_top) || (w_dn_only && w_at_bot));
    assign w_stall_hit  = w_stall_cond && (r_stall == ST_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (ena) begin
            r_stall <= (w_stall_cond && !w_stall_hit) ? r_stall + 1'b1 : '0;
        end
    end
`else
    assign w_stall_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_position;
        w_dwell_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_both)                       w_state_nxt = ST_FAULT;
                else if (w_up_only && !w_at_top)  w_state_nxt = ST_UP;
                else if (w_dn_only && !w_at_bot)  w_state_nxt = ST_DOWN;
                else if (w_stall_hit)             w_state_nxt = ST_FAULT;
            end
            ST_UP: begin
                if (w_both) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_up_only) begin
                    if (w_tick) begin
                        w_pos_nxt = r_position - 1'b1;
                        if (r_position == POS_W'(1)) w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DOWN: begin
                if (w_both) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_dn_only) begin
                    if (w_tick) begin
                        w_pos_nxt = r_position + 1'b1;
                        if (r_position == POS_MAX - 1'b1) w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (w_both)                  w_state_nxt = ST_FAULT;
                else if (r_dwell == DW_LAST) w_state_nxt = ST_IDLE;
                else                         w_dwell_nxt = r_dwell + 1'b1;
            end
            ST_FAULT: begin
                if (!motor_up && !motor_down) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_position <= '0;
            r_dwell    <= '0;
        end else if (ena) begin
            r_state    <= w_state_nxt;
            r_position <= w_pos_nxt;
            r_dwell    <= w_dwell_nxt;
        end
    end

    assign position     = r_position;
    assign limit_top    = w_at_top;
    assign limit_bottom = w_at_bot;
    assign moving       = w_running;
    assign fault        = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_persiana_motor_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_persiana_motor_model
// Brief   : Scoreboard bench for persiana_motor_model (TRAVEL_STEPS=10).
// Rev     : 1.0
// ============================================================================
module tb_persiana_motor_model;

    localparam int TRAVEL = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       motor_up = 1'b0;
    logic       motor_down = 1'b0;
    logic [7:0] position;
    logic       limit_top, limit_bottom, moving, fault;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       tag_q[$];
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    persiana_motor_model #(
        .TRAVEL_STEPS (TRAVEL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .position     (position),
        .limit_top    (limit_top),
        .limit_bottom (limit_bottom),
        .moving       (moving),
        .fault        (fault)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got pos=%0d top/bot/mov/flt=%b, want pos=%0d top/bot/mov/flt=%b",
                     tag, obs[11:4], obs[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    task automatic push_exp(input string tag, input int pos, input logic lt,
                            input logic lb, input logic mv, input logic ft);
        tag_q.push_back(tag);
        exp_q.push_back({8'(pos), lt, lb, mv, ft});
    endtask

    task automatic score();
        while (exp_q.size() > 0) begin
            chk(tag_q.pop_front(), {position, limit_top, limit_bottom, moving, fault},
                exp_q.pop_front());
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(2);
        push_exp("reset", 0, 1, 0, 0, 0);
        score();
        rst_n = 1'b1;

        // Full travel down
        motor_down = 1'b1;
        push_exp("mv_start", 0, 1, 0, 1, 0);
        cyc(1); score();
        push_exp("pre_step", 0, 1, 0, 1, 0);
        cyc(3); score();
        push_exp("step1", 1, 0, 0, 1, 0);
        cyc(1); score();
        push_exp("bottom", TRAVEL, 0, 1, 0, 0);
        cyc(36); score();
        push_exp("hold_bottom", TRAVEL, 0, 1, 0, 0);
        cyc(5); score();
        motor_down = 1'b0;

        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        push_exp("rst2", 0, 1, 0, 0, 0);
        score();

        // Reversal through dwell
        motor_down = 1'b1;
        push_exp("at5", 5, 0, 0, 1, 0);
        cyc(21); score();
        motor_down = 1'b0;
        motor_up   = 1'b1;
        push_exp("dwell_enter", 5, 0, 0, 0, 0);
        cyc(1); score();
        push_exp("dwell_end", 5, 0, 0, 0, 0);
        cyc(8); score();
        push_exp("rev_start", 5, 0, 0, 1, 0);
        cyc(1); score();
        push_exp("rev_pre", 5, 0, 0, 1, 0);
        cyc(3); score();
        push_exp("rev_step", 4, 0, 0, 1, 0);
        cyc(1); score();

        // Both commands while moving
        motor_down = 1'b1;
        push_exp("fault_on", 4, 0, 0, 0, 1);
        cyc(1); score();
        push_exp("fault_hold", 4, 0, 0, 0, 1);
        cyc(6); score();
        motor_down = 1'b0;
        push_exp("fault_one_cmd", 4, 0, 0, 0, 1);
        cyc(2); score();
        motor_up = 1'b0;
        push_exp("fault_clear", 4, 0, 0, 0, 0);
        cyc(1); score();

        // Enable freeze mid-step
        motor_down = 1'b1;
        cyc(3);
        ena = 1'b0;
        push_exp("ena_freeze", 4, 0, 0, 1, 0);
        cyc(20); score();
        ena = 1'b1;
        push_exp("ena_phase", 4, 0, 0, 1, 0);
        cyc(1); score();
        push_exp("ena_step", 5, 0, 0, 1, 0);
        cyc(1); score();

        // Asynchronous reset between edges
        push_exp("at7", 7, 0, 0, 1, 0);
        cyc(8); score();
        #2 rst_n = 1'b0;
        #1;
        push_exp("async_rst", 0, 1, 0, 0, 0);
        score();
        motor_down = 1'b0;
        cyc(1);
        rst_n = 1'b1;

        // Push into the top limit
        motor_up = 1'b1;
`ifdef PERSIANA_STALL_DETECT_EN
        push_exp("stall_pre", 0, 1, 0, 0, 0);
        cyc(15); score();
        push_exp("stall_fault", 0, 1, 0, 0, 1);
        cyc(1); score();
        motor_up = 1'b0;
        push_exp("stall_clear", 0, 1, 0, 0, 0);
        cyc(1); score();
`else
        for (int i = 0; i < 5; i++) begin
            push_exp("no_stall", 0, 1, 0, 0, 0);
            cyc(20); score();
        end
        motor_up = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
